// File: rtl/vga_stream_timing.sv
// Raster timing generator for arbitrary panel geometry, fed from an internal pixel FIFO.
// Optional feature macro VGA_TEST_PATTERN_EN adds a test_en input selecting a 16-pixel grid pattern.
module vga_stream_timing #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int HFP         = 40,
    parameter int HPULSE      = 48,
    parameter int HBP         = 40,
    parameter int VFP         = 13,
    parameter int VPULSE      = 3,
    parameter int VBP         = 29,
    parameter int DATA_W      = 24,
    parameter int FIFO_AW     = 8,
    parameter int START_LEVEL = 2**FIFO_AW - 4,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_en,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              flush_o,
    output logic              HS,
    output logic              VS,
    output logic              BLANK,
    output logic [DATA_W-1:0] RGB,
    output logic              underflow,
    output logic [FIFO_AW:0]  fifo_level
);
    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL) + 1;
    localparam int VW     = $clog2(VTOTAL) + 1;
    localparam int LW     = FIFO_AW + 1;
    localparam int DEPTH  = 2**FIFO_AW;
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;

    typedef enum logic {FILL, RUN} state_t;

`ifndef VGA_TEST_PATTERN_EN
    logic test_en;
    assign test_en = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [HW-1:0]       h_cnt_q, h_cnt_d;
    logic [VW-1:0]       v_cnt_q, v_cnt_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [DATA_W-1:0]   rgb_q, rgb_d;
    logic                uf_q, uf_d, frame_uf_q, frame_uf_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic running, hs_zone, vs_zone, active, h_last, v_last;
    logic fifo_empty, fifo_full, pop_req, pop, uf_now, flush, push;
    int   h_off, v_off;

    always_comb begin
        running    = (state_q == RUN);
        hs_zone    = (h_cnt_q >= HW'(HFP)) && (h_cnt_q < HW'(HFP + HPULSE));
        vs_zone    = (v_cnt_q >= VW'(VFP)) && (v_cnt_q < VW'(VFP + VPULSE));
        active     = (h_cnt_q >= HW'(HSTART)) && (v_cnt_q >= VW'(VSTART));
        h_last     = (h_cnt_q == HW'(HTOTAL - 1));
        v_last     = (v_cnt_q == VW'(VTOTAL - 1));
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LW'(DEPTH));
        pop_req    = running && active && !test_en;
        pop        = pop_req && !fifo_empty;
        // A push landing in an empty FIFO cannot feed the same-cycle pop.
        uf_now     = pop_req && fifo_empty;
        flush      = running && h_last && v_last && (frame_uf_q || uf_now);
        push       = in_valid && !fifo_full && !flush;
        h_off      = int'(h_cnt_q) - HSTART;
        v_off      = int'(v_cnt_q) - VSTART;

        state_d    = state_q;
        h_cnt_d    = '0;
        v_cnt_d    = '0;
        if (!running) begin
            if (test_en || (level_q >= LW'(START_LEVEL)))
                state_d = RUN;
        end else begin
            if (flush)
                state_d = FILL;
            h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
            v_cnt_d = v_cnt_q;
            if (h_last)
                v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end

        uf_d       = uf_q || uf_now;
        frame_uf_d = flush ? 1'b0 : (frame_uf_q || uf_now);

        hs_d    = (running && hs_zone) ? HS_POL : ~HS_POL;
        vs_d    = (running && vs_zone) ? VS_POL : ~VS_POL;
        blank_d = running && active;
        rgb_d   = '0;
        if (running && active) begin
            if (test_en)
                rgb_d = ((h_off % 16) == 0 || (v_off % 16) == 0) ? {DATA_W{1'b1}} : '0;
            else if (pop)
                rgb_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q    <= FILL;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            blank_q    <= 1'b0;
            rgb_q      <= '0;
            uf_q       <= 1'b0;
            frame_uf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_q    <= blank_d;
            rgb_q      <= rgb_d;
            uf_q       <= uf_d;
            frame_uf_q <= frame_uf_d;
        end
    end

    assign in_ready   = !fifo_full;
    assign flush_o    = flush;
    assign HS         = hs_q;
    assign VS         = vs_q;
    assign BLANK      = blank_q;
    assign RGB        = rgb_q;
    assign underflow  = uf_q;
    assign fifo_level = level_q;
endmodule
